// File: rtl/uart_i2c_pkg.sv
// Shared types and constants for the UART command sequencer: FSM states,
// frame header sync pattern, operation modes and error codes.
package uart_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA_LO = 3'd2,
    DATA_HI = 3'd3,
    CHECK   = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  localparam logic [4:0] SYNC_HDR = 5'b10100;

  localparam logic [2:0] MODE_RD1 = 3'b000;
  localparam logic [2:0] MODE_RD2 = 3'b001;
  localparam logic [2:0] MODE_WR1 = 3'b010;
  localparam logic [2:0] MODE_WR2 = 3'b011;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_BAD_HDR = 3'd1,
    ERR_BAD_CHK = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_OVERRUN = 3'd4
  } err_t;

  // Number of payload bytes a frame of this mode carries between ADDR and CHK.
  function automatic logic [1:0] mode_data_bytes(input logic [2:0] m);
    case (m)
      MODE_WR1: return 2'd1;
      MODE_WR2: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_frame_timer.sv
// Inter-byte idle timer: counts enabled idle clocks and flags expiry once the
// count reaches TIMEOUT_CYCLES-1; saturates there so it can never wrap.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frames UART bytes into checksum-verified I2C instructions and pushes each
// one into the arbiter queues with a single aligned set of write strobes.
module uart_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        buffers_full,
  output logic [7:0]  addr_pointer,
  output logic [15:0] wr_data,
  output logic [2:0]  mode,
  output logic        wr_addrbuffer,
  output logic        wr_opbuffer,
  output logic        wr_databuffer1,
  output logic        wr_databuffer2,
  output logic        initiate,
  output logic        busy,
  output logic        cmd_accepted,
  output logic        err_valid,
  output logic [2:0]  err_code
);

  import uart_i2c_pkg::*;

  state_t      state, state_n;
  logic [7:0]  chk, chk_n, addr_n;
  logic [15:0] wdata_n;
  logic [2:0]  mode_n, code_n;
  logic        commit, commit_n, err_n;
  logic        timed, expired;

  assign timed = (state == ADDR) || (state == DATA_LO) ||
                 (state == DATA_HI) || (state == CHECK);

  // Any accepted byte, or being outside the byte-collecting states, restarts the count.
  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!timed || rx_valid),
    .enable  (timed),
    .expired (expired)
  );

  always_comb begin
    state_n  = state;
    chk_n    = chk;
    addr_n   = addr_pointer;
    wdata_n  = wr_data;
    mode_n   = mode;
    code_n   = err_code;
    commit_n = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if ((rx_data[7:3] == SYNC_HDR) && !rx_data[2]) begin
            mode_n  = rx_data[2:0];
            chk_n   = rx_data;
            wdata_n = '0;
            state_n = ADDR;
          end else begin
            err_n  = 1'b1;
            code_n = ERR_BAD_HDR;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          addr_n  = rx_data;
          chk_n   = chk ^ rx_data;
          state_n = (mode_data_bytes(mode) != 2'd0) ? DATA_LO : CHECK;
        end else if (expired) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = IDLE;
        end
      end
      DATA_LO: begin
        if (rx_valid) begin
          wdata_n[7:0] = rx_data;
          chk_n        = chk ^ rx_data;
          state_n      = (mode == MODE_WR2) ? DATA_HI : CHECK;
        end else if (expired) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = IDLE;
        end
      end
      DATA_HI: begin
        if (rx_valid) begin
          wdata_n[15:8] = rx_data;
          chk_n         = chk ^ rx_data;
          state_n       = CHECK;
        end else if (expired) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = IDLE;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == chk) begin
            state_n = COMMIT;
          end else begin
            err_n   = 1'b1;
            code_n  = ERR_BAD_CHK;
            state_n = IDLE;
          end
        end else if (expired) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = IDLE;
        end
      end
      COMMIT: begin
        // An overrun byte defers the commit one cycle so the error pulse and
        // the queue strobes never share a cycle.
        if (rx_valid) begin
          err_n  = 1'b1;
          code_n = ERR_OVERRUN;
        end else if (!buffers_full) begin
          commit_n = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      chk          <= '0;
      addr_pointer <= '0;
      wr_data      <= '0;
      mode         <= '0;
      err_code     <= '0;
      err_valid    <= 1'b0;
      commit       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      chk          <= chk_n;
      addr_pointer <= addr_n;
      wr_data      <= wdata_n;
      mode         <= mode_n;
      err_code     <= code_n;
      err_valid    <= err_n;
      commit       <= commit_n;
      busy         <= (state_n != IDLE);
    end
  end

  assign wr_addrbuffer  = commit;
  assign wr_opbuffer    = commit;
  assign wr_databuffer1 = commit;
  assign wr_databuffer2 = commit;
  assign initiate       = commit;
  assign cmd_accepted   = commit;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed and randomized bench for uart_cmd_sequencer with a frame-level
// reference model predicting committed commands and error reports.
module tb_uart_cmd_sequencer;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        buffers_full = 1'b0;
  logic [7:0]  addr_pointer;
  logic [15:0] wr_data;
  logic [2:0]  mode;
  logic        wr_addrbuffer, wr_opbuffer, wr_databuffer1, wr_databuffer2, initiate;
  logic        busy, cmd_accepted, err_valid;
  logic [2:0]  err_code;

  uart_cmd_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .buffers_full   (buffers_full),
    .addr_pointer   (addr_pointer),
    .wr_data        (wr_data),
    .mode           (mode),
    .wr_addrbuffer  (wr_addrbuffer),
    .wr_opbuffer    (wr_opbuffer),
    .wr_databuffer1 (wr_databuffer1),
    .wr_databuffer2 (wr_databuffer2),
    .initiate       (initiate),
    .busy           (busy),
    .cmd_accepted   (cmd_accepted),
    .err_valid      (err_valid),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        e;
    logic [2:0]  code;
    logic [2:0]  md;
    logic [7:0]  addr;
    logic [15:0] data;
  } ev_t;

  int tests = 0;
  int fails = 0;
  ev_t obs_q[$];
  ev_t exp_q[$];

  // Reference model state: bytes of the frame currently being collected.
  bit         m_active = 1'b0;
  logic [7:0] m_bytes[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk_err(input logic [2:0] code);
    ev_t ev;
    ev = '0;
    ev.e = 1'b1;
    ev.code = code;
    return ev;
  endfunction

  function automatic ev_t mk_cmd(input logic [2:0] md, input logic [7:0] a, input logic [15:0] d);
    ev_t ev;
    ev = '0;
    ev.md = md;
    ev.addr = a;
    ev.data = d;
    return ev;
  endfunction

  function automatic int payload_len(input logic [1:0] m);
    return (m == 2'd3) ? 2 : (m == 2'd2) ? 1 : 0;
  endfunction

  // Frame-level model: a frame is header + addr + payload + checksum; the
  // checksum byte must equal the XOR of everything before it.
  function automatic void model_byte(input logic [7:0] b);
    int need;
    logic [7:0] x;
    int n;
    if (!m_active) begin
      if (b[7:3] == 5'b10100 && !b[2]) begin
        m_active = 1'b1;
        m_bytes.delete();
        m_bytes.push_back(b);
      end else begin
        exp_q.push_back(mk_err(3'd1));
      end
    end else begin
      m_bytes.push_back(b);
      n = payload_len(m_bytes[0][1:0]);
      need = 3 + n;
      if (m_bytes.size() == need) begin
        x = '0;
        for (int i = 0; i < need - 1; i++) x ^= m_bytes[i];
        if (x == b)
          exp_q.push_back(mk_cmd(m_bytes[0][2:0], m_bytes[1],
                                 (n == 2) ? {m_bytes[3], m_bytes[2]} :
                                 (n == 1) ? {8'h00, m_bytes[2]} : 16'h0000));
        else
          exp_q.push_back(mk_err(3'd2));
        m_active = 1'b0;
      end
    end
  endfunction

  function automatic void model_timeout();
    if (m_active) exp_q.push_back(mk_err(3'd3));
    m_active = 1'b0;
  endfunction

  // Monitor samples well after each rising edge, clear of the negedge driver.
  always @(posedge clk) begin
    #2;
    if (wr_addrbuffer | wr_opbuffer | wr_databuffer1 | wr_databuffer2 | initiate | cmd_accepted) begin
      chk("strobe_align", 32'({wr_addrbuffer, wr_opbuffer, wr_databuffer1, wr_databuffer2,
                               initiate, cmd_accepted}), 32'h3f);
      chk("err_with_strobe", 32'(err_valid), 32'h0);
      obs_q.push_back(mk_cmd(mode, addr_pointer, wr_data));
    end
    if (err_valid) obs_q.push_back(mk_err(err_code));
  end

  // All drivers below assume they are called at a falling edge.
  task automatic drive_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    drive_byte(b);
  endtask

  task automatic send_frame(input logic [1:0] m, input logic [7:0] a, input logic [15:0] d,
                            input logic [7:0] flip, input int maxgap);
    logic [7:0] q[$];
    logic [7:0] x;
    q.push_back({5'b10100, 1'b0, m});
    q.push_back(a);
    if (payload_len(m) >= 1) q.push_back(d[7:0]);
    if (payload_len(m) == 2) q.push_back(d[15:8]);
    x = '0;
    foreach (q[i]) x ^= q[i];
    q.push_back(x ^ flip);
    foreach (q[i]) begin
      if (i != 0 && maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      send_byte(q[i]);
    end
  endtask

  task automatic check_events(input string tag);
    int n;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_addr"}, 32'(addr_pointer), 32'h0);
    chk({tag, "_data"}, 32'(wr_data), 32'h0);
    chk({tag, "_mode"}, 32'(mode), 32'h0);
    chk({tag, "_strb"}, 32'({wr_addrbuffer, wr_opbuffer, wr_databuffer1, wr_databuffer2,
                             initiate, cmd_accepted}), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_errv"}, 32'(err_valid), 32'h0);
    chk({tag, "_errc"}, 32'(err_code), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_cleared("reset");

    // Read2 with exact latency: strobes one cycle after the checksum edge.
    send_frame(2'd1, 8'h00, 16'h0, 8'h00, 0);
    chk("rd2_commit_wait", 32'(wr_addrbuffer), 32'h0);
    chk("rd2_busy_commit", 32'(busy), 32'h1);
    @(negedge clk);
    chk("rd2_strobe", 32'(cmd_accepted), 32'h1);
    chk("rd2_fields", 32'({mode, addr_pointer, wr_data}), 32'({3'b001, 8'h00, 16'h0000}));
    chk("rd2_idle", 32'(busy), 32'h0);
    @(negedge clk);
    chk("rd2_pulse_end", 32'(cmd_accepted), 32'h0);
    check_events("rd2");

    send_frame(2'd3, 8'h01, 16'h1234, 8'h00, 0);
    repeat (2) @(negedge clk);
    send_frame(2'd2, 8'h03, 16'h005A, 8'h00, 0);
    repeat (2) @(negedge clk);
    check_events("writes");

    send_byte(8'hA1); send_byte(8'h05); send_byte(8'hFF);
    @(negedge clk);
    send_byte(8'h55);
    send_byte(8'hA4);
    repeat (2) @(negedge clk);
    chk("badhdr_idle", 32'(busy), 32'h0);
    check_events("errors");

    // Silent line after a header: timeout exactly T clocks after it.
    send_byte(8'hA1);
    repeat (T - 1) @(negedge clk);
    chk("to_before", 32'({busy, err_valid}), 32'h2);
    @(negedge clk);
    chk("to_fire", 32'({busy, err_valid, err_code}), 32'({1'b0, 1'b1, 3'd3}));
    model_timeout();
    @(negedge clk);
    send_frame(2'd1, 8'h00, 16'h0, 8'h00, 0);
    repeat (2) @(negedge clk);
    check_events("timeout");

    // Byte landing on the expiry edge wins over the timeout.
    send_byte(8'hA1);
    repeat (T - 1) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'hA1);
    repeat (2) @(negedge clk);
    check_events("expiry_race");

    // Back-pressure with an overrun byte while the command is pending.
    buffers_full = 1'b1;
    drive_byte(8'hA3); drive_byte(8'h01); drive_byte(8'h34); drive_byte(8'h12); drive_byte(8'h84);
    repeat (3) @(negedge clk);
    drive_byte(8'h77);
    repeat (5) @(negedge clk);
    chk("full_hold", 32'({busy, wr_addrbuffer, err_code}), 32'({1'b1, 1'b0, 3'd4}));
    buffers_full = 1'b0;
    @(negedge clk);
    chk("full_release", 32'(initiate), 32'h1);
    @(negedge clk);
    chk("full_once", 32'(initiate), 32'h0);
    exp_q.push_back(mk_err(3'd4));
    exp_q.push_back(mk_cmd(3'b011, 8'h01, 16'h1234));
    check_events("overrun");

    // Reset mid-frame clears everything and drops the partial command.
    send_byte(8'hA3);
    send_byte(8'h01);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_active = 1'b0;
    check_cleared("midreset");
    repeat (4) @(negedge clk);
    send_frame(2'd1, 8'h00, 16'h0, 8'h00, 0);
    repeat (2) @(negedge clk);
    check_events("after_reset");

    // Random mix of valid, corrupted and junk-header traffic.
    for (int it = 0; it < 40; it++) begin
      logic [7:0] b;
      if ($urandom_range(0, 5) == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b[7:3] == 5'b10100 && !b[2]) b = b ^ 8'h80;
        send_byte(b);
      end else begin
        send_frame(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                   16'($urandom_range(0, 65535)),
                   ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00, 3);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_events("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
